// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         DEPTH_DEF  = 256;
  localparam int         ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_LEN_H = 3'd1,
    ST_LEN_L = 3'd2,
    ST_DAT_H = 3'd3,
    ST_DAT_L = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

endpackage

// File: rtl/imem_frame_fsm.sv
// Frame sequencer: tracks position in the frame, the word length and the
// word counter, and produces the registered handshake/write/status outputs.
//
// state | meaning
// HUNT  | discard bytes until the sync byte arrives
// LEN_H | expecting length high byte
// LEN_L | expecting length low byte; range-check N
// DAT_H | expecting high byte of the next word
// DAT_L | expecting low byte; schedules the memory write
// CSUM  | expecting checksum byte
// DONE  | load good, CPU released, waits for restart
// ERR   | load failed, CPU held, waits for restart
module imem_frame_fsm
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W = ADDR_W_DEF,
  parameter int         DEPTH  = DEPTH_DEF,
  parameter logic [7:0] SYNC   = SYNC_BYTE
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_accept,
  input  logic [7:0]        i_byte,
  input  logic              i_restart,
  input  logic              i_csum_ok,
  output state_e            o_state,
  output logic              o_in_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_cpu_run,
  output logic              o_load_err,
  output logic [ADDR_W-1:0] o_words_loaded
);

  state_e            r_state;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [ADDR_W-1:0] r_words;
  logic              r_ready;
  logic              r_wr_en;
  logic              r_cpu_run;
  logic              r_load_err;

  logic [15:0] w_len_in;
  logic        w_last_word;
  logic        w_terminal;

  assign w_len_in    = {r_len_hi, i_byte};
  // The previous word's counter increment has always landed by the time the
  // next low byte can be accepted, so r_words is the index being written.
  assign w_last_word = ((32'(r_words) + 32'd1) == 32'(r_len));
  assign w_terminal  = (r_state == ST_DONE) || (r_state == ST_ERR);

  // Frame sequencing, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_HUNT;
      r_len_hi   <= 8'd0;
      r_len      <= 16'd0;
      r_words    <= '0;
      r_ready    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_cpu_run  <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_ready <= !w_terminal;
      r_wr_en <= 1'b0;
      if (r_wr_en) r_words <= r_words + ADDR_W'(1);

      if (i_restart && w_terminal) begin
        r_state    <= ST_HUNT;
        r_cpu_run  <= 1'b0;
        r_load_err <= 1'b0;
        r_words    <= '0;
        r_ready    <= 1'b1;
      end else if (i_accept) begin
        case (r_state)
          ST_HUNT: begin
            if (i_byte == SYNC) r_state <= ST_LEN_H;
          end
          ST_LEN_H: begin
            r_len_hi <= i_byte;
            r_state  <= ST_LEN_L;
          end
          ST_LEN_L: begin
            r_len   <= w_len_in;
            r_words <= '0;
            if (32'(w_len_in) > 32'(DEPTH)) begin
              r_state    <= ST_ERR;
              r_load_err <= 1'b1;
              r_ready    <= 1'b0;
            end else if (w_len_in == 16'd0) begin
              r_state <= ST_CSUM;
            end else begin
              r_state <= ST_DAT_H;
            end
          end
          ST_DAT_H: begin
            r_state <= ST_DAT_L;
          end
          ST_DAT_L: begin
            r_wr_en <= 1'b1;
            r_state <= w_last_word ? ST_CSUM : ST_DAT_H;
          end
          ST_CSUM: begin
            r_ready <= 1'b0;
            if (i_csum_ok) begin
              r_state   <= ST_DONE;
              r_cpu_run <= 1'b1;
            end else begin
              r_state    <= ST_ERR;
              r_load_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_state        = r_state;
  assign o_in_ready     = r_ready;
  assign o_wr_en        = r_wr_en;
  assign o_wr_addr      = r_words;
  assign o_cpu_run      = r_cpu_run;
  assign o_load_err     = r_load_err;
  assign o_words_loaded = r_words;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream in, 16-bit instruction-memory writes out,
// CPU held in reset until a frame with a good checksum completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W = ADDR_W_DEF,
  parameter int         DEPTH  = DEPTH_DEF,
  parameter logic [7:0] SYNC   = SYNC_BYTE
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_restart,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_cpu_run,
  output logic              o_load_err,
  output logic [ADDR_W-1:0] o_words_loaded
);

  state_e      w_state;
  logic        w_ready;
  logic        w_accept;
  logic        w_csum_ok;
  logic [7:0]  r_csum;
  logic [7:0]  r_hi;
  logic [15:0] r_wr_data;

  assign w_accept  = i_in_valid && w_ready;
  assign w_csum_ok = (i_in_data == r_csum);

  imem_frame_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .SYNC   (SYNC)
  ) u_fsm (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_accept       (w_accept),
    .i_byte         (i_in_data),
    .i_restart      (i_restart),
    .i_csum_ok      (w_csum_ok),
    .o_state        (w_state),
    .o_in_ready     (w_ready),
    .o_wr_en        (o_wr_en),
    .o_wr_addr      (o_wr_addr),
    .o_cpu_run      (o_cpu_run),
    .o_load_err     (o_load_err),
    .o_words_loaded (o_words_loaded)
  );

  // Payload checksum and big-endian word assembly; the write data register
  // lines up with the FSM's registered write strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csum    <= 8'd0;
      r_hi      <= 8'd0;
      r_wr_data <= 16'd0;
    end else if (w_accept) begin
      case (w_state)
        ST_LEN_L: r_csum <= 8'd0;
        ST_DAT_H: begin
          r_hi   <= i_in_data;
          r_csum <= r_csum + i_in_data;
        end
        ST_DAT_L: begin
          r_csum    <= r_csum + i_in_data;
          r_wr_data <= {r_hi, i_in_data};
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready = w_ready;
  assign o_wr_data  = r_wr_data;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_in_data = 8'd0;
  logic        i_in_valid = 1'b0;
  logic        i_restart = 1'b0;
  logic        o_in_ready;
  logic        o_wr_en;
  logic [15:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_cpu_run;
  logic        o_load_err;
  logic [15:0] o_words_loaded;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  imem_loader dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_in_data      (i_in_data),
    .i_in_valid     (i_in_valid),
    .o_in_ready     (o_in_ready),
    .i_restart      (i_restart),
    .o_wr_en        (o_wr_en),
    .o_wr_addr      (o_wr_addr),
    .o_wr_data      (o_wr_data),
    .o_cpu_run      (o_cpu_run),
    .o_load_err     (o_load_err),
    .o_words_loaded (o_words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && o_wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_addr", {16'd0, o_wr_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("wr_addr", {16'd0, o_wr_addr}, {16'd0, e[31:16]});
        chk("wr_data", {16'd0, o_wr_data}, {16'd0, e[15:0]});
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    @(negedge clk);
    if (gap) begin
      repeat ($urandom_range(0, 2)) begin
        i_in_valid = 1'b0;
        i_in_data  = 8'hA5;
        @(negedge clk);
      end
    end
    i_in_valid = 1'b1;
    i_in_data  = b;
    n = 0;
    while (!o_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_in_data  = 8'h00;
  endtask

  task automatic frame(input logic [15:0] w[$], input bit gap, input logic [7:0] delta);
    logic [7:0]  cs;
    logic [15:0] n;
    cs = 8'd0;
    n  = 16'(w.size());
    send(8'hA5, gap);
    send(n[15:8], gap);
    send(n[7:0], gap);
    for (int i = 0; i < w.size(); i++) begin
      logic [15:0] wd;
      wd = w[i];
      sb.push_back({16'(i), wd});
      cs = cs + wd[15:8] + wd[7:0];
      send(wd[15:8], gap);
      send(wd[7:0], gap);
    end
    send(cs + delta, gap);
    @(negedge clk);
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    i_restart = 1'b1;
    @(negedge clk);
    i_restart = 1'b0;
  endtask

  initial begin
    logic [15:0] q[$];

    // reset values
    #2;
    chk("rst_ready", {31'd0, o_in_ready}, 0);
    chk("rst_wr_en", {31'd0, o_wr_en}, 0);
    chk("rst_wr_addr", {16'd0, o_wr_addr}, 0);
    chk("rst_wr_data", {16'd0, o_wr_data}, 0);
    chk("rst_cpu_run", {31'd0, o_cpu_run}, 0);
    chk("rst_load_err", {31'd0, o_load_err}, 0);
    chk("rst_words", {16'd0, o_words_loaded}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ready_after_rst", {31'd0, o_in_ready}, 1);

    // good two-word frame, checksum 0xB6
    q = '{16'h7000, 16'h1234};
    frame(q, 1'b0, 8'd0);
    chk("a_cpu_run", {31'd0, o_cpu_run}, 1);
    chk("a_load_err", {31'd0, o_load_err}, 0);
    chk("a_words", {16'd0, o_words_loaded}, 2);
    chk("a_ready", {31'd0, o_in_ready}, 0);
    chk("a_sb_empty", 32'(sb.size()), 0);

    // garbage ahead of sync, checksum wraps (0x178 -> 0x78)
    pulse_restart();
    chk("rs_ready", {31'd0, o_in_ready}, 1);
    chk("rs_cpu_run", {31'd0, o_cpu_run}, 0);
    chk("rs_words", {16'd0, o_words_loaded}, 0);
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h5A, 1'b0);
    q = '{16'hABCD};
    frame(q, 1'b0, 8'd0);
    chk("b_cpu_run", {31'd0, o_cpu_run}, 1);
    chk("b_sb_empty", 32'(sb.size()), 0);

    // bad checksum: write still happens, then ERR
    pulse_restart();
    q = '{16'h1122};
    frame(q, 1'b0, 8'hCD);
    chk("c_load_err", {31'd0, o_load_err}, 1);
    chk("c_cpu_run", {31'd0, o_cpu_run}, 0);
    chk("c_ready", {31'd0, o_in_ready}, 0);
    chk("c_sb_empty", 32'(sb.size()), 0);
    pulse_restart();
    chk("c_rs_err", {31'd0, o_load_err}, 0);
    chk("c_rs_ready", {31'd0, o_in_ready}, 1);

    // oversize length 257
    send(8'hA5, 1'b0);
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    @(negedge clk);
    chk("d_load_err", {31'd0, o_load_err}, 1);
    chk("d_ready", {31'd0, o_in_ready}, 0);
    chk("d_cpu_run", {31'd0, o_cpu_run}, 0);

    // empty frames
    pulse_restart();
    q.delete();
    frame(q, 1'b0, 8'd0);
    chk("e_cpu_run", {31'd0, o_cpu_run}, 1);
    chk("e_words", {16'd0, o_words_loaded}, 0);
    pulse_restart();
    frame(q, 1'b0, 8'd1);
    chk("e_bad_err", {31'd0, o_load_err}, 1);
    chk("e_bad_run", {31'd0, o_cpu_run}, 0);

    // four words with random stalls
    pulse_restart();
    q = '{16'hDEAD, 16'hBEEF, 16'h0F1E, 16'h8001};
    frame(q, 1'b1, 8'd0);
    chk("f_cpu_run", {31'd0, o_cpu_run}, 1);
    chk("f_words", {16'd0, o_words_loaded}, 4);
    chk("f_sb_empty", 32'(sb.size()), 0);

    // N == DEPTH is accepted
    pulse_restart();
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(16'(i * 16'h0101) ^ 16'h5A3C);
    frame(q, 1'b0, 8'd0);
    chk("g_cpu_run", {31'd0, o_cpu_run}, 1);
    chk("g_words", {16'd0, o_words_loaded}, 256);
    chk("g_sb_empty", 32'(sb.size()), 0);

    // async reset while a low byte is pending
    pulse_restart();
    sb.push_back({16'd0, 16'h0102});
    send(8'hA5, 1'b0);
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    @(negedge clk);
    i_in_valid = 1'b1;
    i_in_data  = 8'h04;
    #2;
    rst_n = 1'b0;
    #1;
    chk("h_ready", {31'd0, o_in_ready}, 0);
    chk("h_wr_en", {31'd0, o_wr_en}, 0);
    chk("h_wr_addr", {16'd0, o_wr_addr}, 0);
    chk("h_words", {16'd0, o_words_loaded}, 0);
    chk("h_cpu_run", {31'd0, o_cpu_run}, 0);
    chk("h_sb_empty", 32'(sb.size()), 0);
    i_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q = '{16'hBEEF};
    frame(q, 1'b0, 8'd0);
    chk("h2_cpu_run", {31'd0, o_cpu_run}, 1);
    chk("h2_words", {16'd0, o_words_loaded}, 1);
    chk("h2_sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader, the writer side of the instruction memory that the pipelined CPU's fetch stage reads.
- Accepts a framed byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them to consecutive instruction-memory addresses from 0.
- Holds the CPU in reset (cpu_run low) until a frame completes with a good checksum.
- Sits between the host byte source (UART receiver or testbench) and the I_memory write port plus CPU reset.

Parameters:
- ADDR_W, 16, width of the instruction-memory word address.
- DEPTH, 256, number of instruction words that may be loaded; frames longer than this are rejected.
- SYNC, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle. A byte transfers when in_valid && in_ready.
- restart  in  1  one-cycle pulse; leaves DONE/ERR and starts a new load.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  write word address.
- wr_data  out  16  write word, {hi byte, lo byte}.
- cpu_run  out  1  high = CPU released from reset. Drive CPU Rst from this output.
- load_err  out  1  sticky error flag until restart or reset.
- words_loaded  out  ADDR_W  words written in the current frame.

Behaviour:
- Reset (async, Rst=0): state=HUNT; in_ready=0 during reset; wr_en=0; wr_addr=0; wr_data=0; cpu_run=0; load_err=0; words_loaded=0; checksum=0; length=0.
- Frame format: SYNC, LEN_HI, LEN_LO, N×(WORD_HI, WORD_LO), CSUM.
  - N = {LEN_HI, LEN_LO}.
  - CSUM = 8-bit modulo-256 sum of all 2N payload bytes. Sync and length bytes are excluded.
- States and transitions (all move only on an accepted byte unless noted):
  - HUNT: in_ready=1. SYNC → LEN_H. Any other byte is discarded, state stays HUNT.
  - LEN_H: store hi byte → LEN_L.
  - LEN_L: form N.
    - N > DEPTH → ERR.
    - N == 0 → CSUM.
    - Otherwise → DAT_H. Clear checksum, wr_addr and words_loaded.
  - DAT_H: latch byte; checksum += byte → DAT_L.
  - DAT_L: checksum += byte.
    - Next cycle: wr_en=1 for exactly one cycle, wr_data={latched hi, this byte}, wr_addr = current word index.
    - After the write cycle, wr_addr and words_loaded increment.
    - If this was word N → CSUM, else → DAT_H.
  - CSUM: byte == checksum → DONE, else → ERR.
  - DONE: in_ready=0, cpu_run=1. Stays until restart or reset.
  - ERR: in_ready=0, load_err=1, cpu_run=0. Stays until restart or reset.
- Latency: an accepted byte is processed in the same edge. wr_en is registered, so it rises 1 cycle after the accepted WORD_LO. cpu_run rises 1 cycle after the accepted CSUM byte.
- Throughput: one byte per cycle sustained; in_ready stays 1 through the wr_en cycle. Back-to-back words give wr_en every 2nd cycle.
- Handshake stalls: in_valid=0 holds all state. in_data is ignored when in_valid=0.
- restart:
  - In DONE or ERR → HUNT; cpu_run=0, load_err=0, words_loaded=0.
  - In any other state → ignored.
  - Simultaneous with an accepted byte: restart wins only in DONE/ERR, where no byte can be accepted anyway.
- Reset mid-frame: all state clears asynchronously. Memory contents already written are not undone.
- Arithmetic:
  - Checksum wraps at 8 bits.
  - wr_addr never exceeds DEPTH-1, because N ≤ DEPTH is checked before any write.
  - N == DEPTH is legal.

Decomposition:
- Shared package/define file: SYNC byte value, state encodings (HUNT, LEN_H, LEN_L, DAT_H, DAT_L, CSUM, DONE, ERR), default DEPTH.
- One natural sub-module: imem_frame_fsm, holding state and the length/word counters.
- Checksum accumulator and word assembly stay in the top level.

Test Plan:
- Good frame A5 00 02 70 00 12 34 + csum (0x70+0x00+0x12+0x34=0xB6), in_valid continuous → wr_en pulses: addr0 data 7000, addr1 data 1234. Then cpu_run=1, load_err=0, words_loaded=2, in_ready=0.
- Garbage 00 FF 5A before A5 00 01 AB CD 78 (0xAB+0xCD=0x178) → leading bytes discarded; one write addr0=ABCD; cpu_run=1.
- Bad checksum A5 00 01 11 22 00 (expected 0x33) → one write still occurs; load_err=1, cpu_run=0. restart pulse → HUNT, load_err=0, in_ready=1.
- Oversize A5 01 01 (N=257 > DEPTH 256) → ERR immediately; no wr_en ever asserted.
- N=0 frame A5 00 00 00 → DONE, cpu_run=1, no writes. Same frame with CSUM 01 → ERR.
- in_valid toggled randomly 50% during a 4-word frame → identical writes to the continuous case. Rst asserted mid-DAT_L → all outputs at reset values immediately (async); next SYNC starts a fresh frame from addr0.
